// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder:
// FSM state encoding, latency counter width and the zero/NOP data word.
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned CNT_W    = 4;
   localparam logic [15:0] NOP_WORD = 16'h0000;

   // Word index for a power-of-two depth; the modulo reduces to dropping upper bits.
   function automatic logic [31:0] wrap_index(input logic [31:0] addr, input logic [31:0] depth);
      return addr % depth;
   endfunction

endpackage

// File: rtl/imem_fetch_responder_array.sv
// DEPTH x DATA_W instruction storage: one synchronous write port and one
// combinational read port. The parent captures the read word, which gives read-before-write ordering.
module imem_array #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned IDX_W  = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory end of the fetch interface: request handshake, fixed-latency
// response handshake and a loader write port. Define IMEM_BOUNDS_CHECK_EN for resp_err and range checks.
module imem_fetch_responder
   import imem_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy
`ifdef IMEM_BOUNDS_CHECK_EN
   ,
   output logic              resp_err
`endif
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;
   logic [DATA_W-1:0] rd_word;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  wr_idx;
   logic              wr_we;

   assign rd_idx = IDX_W'(wrap_index(32'(req_addr), 32'(DEPTH)));
   assign wr_idx = IDX_W'(wrap_index(32'(wr_addr), 32'(DEPTH)));

`ifdef IMEM_BOUNDS_CHECK_EN
   logic req_oob;
   logic wr_oob;
   logic err_q;
   logic err_d;

   assign req_oob  = 32'(req_addr) >= 32'(DEPTH);
   assign wr_oob   = 32'(wr_addr) >= 32'(DEPTH);
   assign wr_we    = wr_en && !wr_oob;
   assign data_d   = req_oob ? DATA_W'(NOP_WORD) : rd_word;
   assign err_d    = req_oob;
   assign resp_err = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state_q == IDLE && req_valid) begin
         err_q <= err_d;
      end
   end
`else
   assign wr_we  = wr_en;
   assign data_d = rd_word;
`endif

   imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_we),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_word)
   );

   // The word is captured on the accept edge, so a same-edge or later write cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= DATA_W'(NOP_WORD);
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  data_q <= data_d;
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                  end else begin
                     cnt_q   <= CNT_W'(LATENCY - 1);
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign resp_data  = data_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: a LATENCY=2 and a LATENCY=1 instance
// checked every cycle against a timestamp-based model plus literal expectations.
module tb_imem_fetch_responder;

   localparam int DEPTH = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        req_valid_a [2];
   logic [15:0] req_addr_a  [2];
   logic        resp_ready_a[2];

   logic        req_ready0, resp_valid0, busy0;
   logic        req_ready1, resp_valid1, busy1;
   logic [15:0] resp_data0, resp_data1;
   logic        req_ready_a [2];
   logic        resp_valid_a[2];
   logic        busy_a      [2];
   logic [15:0] resp_data_a [2];

   assign req_ready_a[0]  = req_ready0;
   assign req_ready_a[1]  = req_ready1;
   assign resp_valid_a[0] = resp_valid0;
   assign resp_valid_a[1] = resp_valid1;
   assign busy_a[0]       = busy0;
   assign busy_a[1]       = busy1;
   assign resp_data_a[0]  = resp_data0;
   assign resp_data_a[1]  = resp_data1;

   imem_fetch_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(2)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_a[0]), .req_ready(req_ready0), .req_addr(req_addr_a[0]),
      .resp_valid(resp_valid0), .resp_ready(resp_ready_a[0]), .resp_data(resp_data0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy0)
   );

   imem_fetch_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_a[1]), .req_ready(req_ready1), .req_addr(req_addr_a[1]),
      .resp_valid(resp_valid1), .resp_ready(resp_ready_a[1]), .resp_data(resp_data1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy1)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit chk_en      = 0;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endfunction

   // Model: a fetch is in flight from its accept edge; it becomes visible once
   // 'age' (cycles since accept) reaches the latency, and retires on a ready edge.
   int          lat_m [2] = '{2, 1};
   bit          busy_m[2];
   int          age_m [2];
   logic [15:0] data_m[2];
   logic [15:0] shadow[DEPTH];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            busy_m[i] = 0;
            data_m[i] = 16'h0000;
         end else if (!busy_m[i]) begin
            if (req_valid_a[i]) begin
               busy_m[i] = 1;
               age_m[i]  = 1;
               data_m[i] = shadow[int'(req_addr_a[i]) % DEPTH];
            end
         end else if (age_m[i] >= lat_m[i]) begin
            if (resp_ready_a[i]) busy_m[i] = 0;
         end else begin
            age_m[i]++;
         end
      end
      if (wr_en) shadow[int'(wr_addr) % DEPTH] = wr_data;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("cyc%0d inst%0d req_ready", cyc, i), 32'(req_ready_a[i]), 32'(!busy_m[i]));
            chk($sformatf("cyc%0d inst%0d resp_valid", cyc, i), 32'(resp_valid_a[i]),
                32'(busy_m[i] && age_m[i] >= lat_m[i]));
            chk($sformatf("cyc%0d inst%0d busy", cyc, i), 32'(busy_a[i]), 32'(busy_m[i]));
            chk($sformatf("cyc%0d inst%0d resp_data", cyc, i), 32'(resp_data_a[i]), 32'(data_m[i]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Present one request to an idle instance and wait (bounded) for its response.
   task automatic fetch(input int i, input logic [15:0] addr, input logic rdy,
                        input logic do_wr, input logic [15:0] waddr, input logic [15:0] wdata,
                        output logic [15:0] data, output int lat_seen);
      int acc;
      bit seen;
      req_valid_a[i]  = 1'b1;
      req_addr_a[i]   = addr;
      resp_ready_a[i] = rdy;
      if (do_wr) begin
         wr_en = 1'b1; wr_addr = waddr; wr_data = wdata;
      end
      tick();
      acc = cyc;
      req_valid_a[i] = 1'b0;
      wr_en = 1'b0;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         if (resp_valid_a[i] === 1'b1) begin
            seen = 1;
            break;
         end
         tick();
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL inst%0d fetch %h timeout: resp_valid low after 30 cycles, required high", i, addr);
      end
      data     = resp_data_a[i];
      lat_seen = cyc - acc + 1;
      $display("fetch inst%0d addr=%h data=%h latency=%0d", i, addr, data, lat_seen);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      int          l;
      logic [15:0] got_q[$];
      int          acc_q[$];
      int          k;
      bit          will_acc;

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      for (int i = 0; i < 2; i++) begin
         req_valid_a[i] = 1'b0; req_addr_a[i] = '0; resp_ready_a[i] = 1'b1;
      end
      tick();
      chk_en = 1;

      // Fill memory with word = address while reset is held.
      for (int a = 0; a < DEPTH; a++) begin
         wr_en = 1'b1; wr_addr = 16'(a); wr_data = 16'(a);
         tick();
      end
      rst = 1'b0;
      wr_addr = 16'd5; wr_data = 16'h1234;
      tick();
      wr_en = 1'b0;
      $display("load done, mem[5]=1234");
      chk("reset req_ready", 32'(req_ready0), 32'd1);
      chk("reset resp_valid", 32'(resp_valid0), 32'd0);
      chk("reset busy", 32'(busy0), 32'd0);
      chk("reset resp_data", 32'(resp_data0), 32'h0);

      // Basic fetch, latency 2
      fetch(0, 16'd5, 1'b1, 1'b0, 16'd0, 16'd0, d, l);
      chk("A data", 32'(d), 32'h1234);
      chk("A latency", 32'(l), 32'd2);
      tick();
      chk("A req_ready after", 32'(req_ready0), 32'd1);
      chk("A resp_valid after", 32'(resp_valid0), 32'd0);

      // Back-pressure on the response
      fetch(0, 16'd5, 1'b0, 1'b0, 16'd0, 16'd0, d, l);
      chk("B data", 32'(d), 32'h1234);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("B hold resp_valid", 32'(resp_valid0), 32'd1);
         chk("B hold resp_data", 32'(resp_data0), 32'h1234);
         chk("B hold req_ready", 32'(req_ready0), 32'd0);
      end
      resp_ready_a[0] = 1'b1;
      tick();
      chk("B req_ready after", 32'(req_ready0), 32'd1);
      chk("B busy after", 32'(busy0), 32'd0);

      // Write and accept on the same edge to the same index
      fetch(0, 16'd7, 1'b1, 1'b1, 16'd7, 16'hBEEF, d, l);
      chk("C old data", 32'(d), 32'h0007);
      tick();
      fetch(0, 16'd7, 1'b1, 1'b0, 16'd0, 16'd0, d, l);
      chk("C new data", 32'(d), 32'hBEEF);
      tick();

      // Reset during WAIT, with a write on the reset edge
      req_valid_a[0] = 1'b1; req_addr_a[0] = 16'd5;
      tick();
      req_valid_a[0] = 1'b0;
      rst = 1'b1; wr_en = 1'b1; wr_addr = 16'd9; wr_data = 16'hA5A5;
      tick();
      rst = 1'b0; wr_en = 1'b0;
      $display("reset during WAIT, write 9=A5A5 on reset edge");
      chk("D busy after reset", 32'(busy0), 32'd0);
      chk("D req_ready after reset", 32'(req_ready0), 32'd1);
      for (int c = 0; c < 4; c++) begin
         chk("D resp_valid stays low", 32'(resp_valid0), 32'd0);
         tick();
      end
      fetch(0, 16'd5, 1'b1, 1'b0, 16'd0, 16'd0, d, l);
      chk("D refetch", 32'(d), 32'h1234);
      tick();
      fetch(0, 16'd9, 1'b1, 1'b0, 16'd0, 16'd0, d, l);
      chk("D reset-edge write", 32'(d), 32'hA5A5);
      tick();

      // Address wrap-around
      fetch(0, 16'h0105, 1'b1, 1'b0, 16'd0, 16'd0, d, l);
      chk("E wrap 0105", 32'(d), 32'h1234);
      tick();
      fetch(0, 16'hFF07, 1'b1, 1'b0, 16'd0, 16'd0, d, l);
      chk("E wrap FF07", 32'(d), 32'hBEEF);
      tick();

      // LATENCY=1 instance, request held valid back to back
      k = 0;
      resp_ready_a[1] = 1'b1;
      req_valid_a[1]  = 1'b1;
      req_addr_a[1]   = 16'd10;
      for (int c = 0; c < 40 && got_q.size() < 5; c++) begin
         will_acc = req_ready_a[1] && req_valid_a[1];
         tick();
         if (will_acc) begin
            acc_q.push_back(cyc);
            k++;
            if (k < 5) req_addr_a[1] = 16'(10 + k);
            else req_valid_a[1] = 1'b0;
         end
         if (resp_valid_a[1] === 1'b1) begin
            got_q.push_back(resp_data_a[1]);
            $display("fetch inst1 response %0d data=%h", got_q.size() - 1, resp_data_a[1]);
         end
      end
      req_valid_a[1] = 1'b0;
      chk("F response count", 32'(got_q.size()), 32'd5);
      chk("F accept count", 32'(acc_q.size()), 32'd5);
      for (int j = 0; j < got_q.size() && j < 5; j++)
         chk($sformatf("F response %0d", j), 32'(got_q[j]), 32'(10 + j));
      for (int j = 1; j < acc_q.size(); j++)
         chk($sformatf("F accept spacing %0d", j), 32'(acc_q[j] - acc_q[j-1]), 32'd2);

      tick();
      tick();
      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
